// File: rtl/regfile_check_monitor_if.sv
// regfile_check_monitor_if: harness-side bus of the end-of-test register-file checker
interface regfile_check_monitor_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int IDX_BITS     = 5,
    parameter int ADDRESS_BITS = 20
);
    logic                    start;
    logic [ADDRESS_BITS-1:0] pc;
    logic                    exp_we;
    logic [IDX_BITS-1:0]     exp_idx;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic [DATA_WIDTH-1:0]   exp_mask;
    logic [IDX_BITS-1:0]     rf_sel;
    logic [DATA_WIDTH-1:0]   rf_data;
    logic                    busy;
    logic                    done;
    logic                    passed;
    logic                    timed_out;
    logic [IDX_BITS:0]       mismatch_count;
    logic [IDX_BITS-1:0]     first_bad_idx;
    logic [DATA_WIDTH-1:0]   first_bad_value;
    modport master (
        output start, pc, exp_we, exp_idx, exp_data, exp_mask, rf_data,
        input  rf_sel, busy, done, passed, timed_out, mismatch_count, first_bad_idx, first_bad_value
    );
    modport slave (
        input  start, pc, exp_we, exp_idx, exp_data, exp_mask, rf_data,
        output rf_sel, busy, done, passed, timed_out, mismatch_count, first_bad_idx, first_bad_value
    );
endinterface

// File: rtl/regfile_check_monitor.sv
// regfile_check_monitor: waits for core halt (parked PC) or timeout, then walks the register
// file against a masked expected-value table and reports pass/fail details.
module regfile_check_monitor #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 32,
    parameter int IDX_BITS      = 5,
    parameter int ADDRESS_BITS  = 20,
    parameter int TIMEOUT       = 100,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_BITS      = 16
) (
    input logic clk,
    input logic rst,
    regfile_check_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
    localparam logic [IDX_BITS:0]   LAST = (IDX_BITS+1)'(NUM_REGS);
    localparam logic [CNT_BITS-1:0] TO   = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] ST   = CNT_BITS'(STABLE_CYCLES);
    state_t                  state_q, state_d;
    logic [CNT_BITS-1:0]     cyc_q, cyc_d, stab_q, stab_d, cyc_inc, stab_inc;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic                    seen_q, seen_d, to_q, to_d, tbl_we, miss;
    logic [IDX_BITS:0]       cnt_q, cnt_d, mm_q, mm_d;
    logic [IDX_BITS-1:0]     fbi_q, fbi_d, k;
    logic [DATA_WIDTH-1:0]   fbv_q, fbv_d;
    logic [DATA_WIDTH-1:0]   tbl_data_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   tbl_mask_q [NUM_REGS];
    assign cyc_inc  = &cyc_q ? cyc_q : cyc_q + CNT_BITS'(1);
    assign stab_inc = &stab_q ? stab_q : stab_q + CNT_BITS'(1);
    // compare slot k belongs to the select issued one cycle earlier
    assign k    = cnt_q[IDX_BITS-1:0] - IDX_BITS'(1);
    assign miss = (state_q == CHECK) && (cnt_q != '0) &&
                  |((bus.rf_data ^ tbl_data_q[k]) & tbl_mask_q[k]);
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stab_d  = stab_q;
        pc_d    = pc_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        mm_d    = mm_q;
        fbi_d   = fbi_q;
        fbv_d   = fbv_q;
        tbl_we  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                tbl_we = bus.exp_we && ({1'b0, bus.exp_idx} < LAST);
                if (bus.start) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    stab_d  = '0;
                    seen_d  = 1'b0;
                    to_d    = 1'b0;
                    mm_d    = '0;
                    fbi_d   = '0;
                    fbv_d   = '0;
                end
            end
            RUN: begin
                cyc_d  = cyc_inc;
                stab_d = (seen_q && bus.pc == pc_q) ? stab_inc : '0;
                pc_d   = bus.pc;
                seen_d = 1'b1;
                // halt detection takes priority over a timeout in the same cycle
                if (stab_d >= ST || cyc_d >= TO) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    to_d    = stab_d < ST;
                end
            end
            CHECK: begin
                cnt_d = cnt_q + (IDX_BITS+1)'(1);
                if (miss) begin
                    mm_d  = mm_q + (IDX_BITS+1)'(1);
                    fbi_d = (mm_q == '0) ? k : fbi_q;
                    fbv_d = (mm_q == '0) ? bus.rf_data : fbv_q;
                end
                state_d = (cnt_q == LAST) ? DONE : CHECK;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            stab_q  <= '0;
            pc_q    <= '0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            mm_q    <= '0;
            fbi_q   <= '0;
            fbv_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stab_q  <= stab_d;
            pc_q    <= pc_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            mm_q    <= mm_d;
            fbi_q   <= fbi_d;
            fbv_q   <= fbv_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tbl_data_q[i] <= '0;
                tbl_mask_q[i] <= '1;
            end
        end else if (tbl_we) begin
            tbl_data_q[bus.exp_idx] <= bus.exp_data;
            tbl_mask_q[bus.exp_idx] <= bus.exp_mask;
        end
    end
    assign bus.rf_sel          = (state_q == CHECK && cnt_q != LAST) ? cnt_q[IDX_BITS-1:0] : '0;
    assign bus.busy            = state_q == RUN || state_q == CHECK;
    assign bus.done            = state_q == DONE;
    assign bus.passed          = bus.done && !to_q && mm_q == '0;
    assign bus.timed_out       = to_q;
    assign bus.mismatch_count  = mm_q;
    assign bus.first_bad_idx   = fbi_q;
    assign bus.first_bad_value = fbv_q;
endmodule
